// File: rtl/usb_txn_ctrl.sv
// USB host transaction sequencer: orders token/data/handshake sub-FSMs, tracks per-endpoint
// data toggles, retries failed attempts and times out silent receivers. Strobes and pid are registered.
module usb_txn_ctrl #(
    parameter int NUM_EP      = 4,
    parameter int MAX_RETRY   = 8,
    parameter int TIMEOUT_CYC = 255,
    localparam int EPW        = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           start,
    input  logic           read_write,
    input  logic [EPW-1:0] ep,
    input  logic           clr_toggle,
    input  logic           done_send_token,
    input  logic           done_send_data,
    input  logic           done_send_hand,
    input  logic           rx_hand_valid,
    input  logic           rx_ack,
    input  logic           rx_nak,
    input  logic           rx_hand_fail,
    input  logic           rx_data_done,
    input  logic           rx_data_ok,
    input  logic           rx_data_fail,
    input  logic           rx_data_toggle,
    output logic           start_send_token,
    output logic           start_send_data,
    output logic           start_send_hand,
    output logic           r_data_start,
    output logic           r_hand_start,
    output logic [7:0]     pid,
    output logic           busy,
    output logic           system_done,
    output logic           process_success,
    output logic           data_dup,
    output logic [3:0]     retry_count
);
    localparam int TMW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] PID_OUT   = 8'b1000_0111;
    localparam logic [7:0] PID_IN    = 8'b1001_0110;
    localparam logic [7:0] PID_DATA0 = 8'b1100_0011;
    localparam logic [7:0] PID_DATA1 = 8'b1101_0010;
    localparam logic [7:0] PID_ACK   = 8'b0100_1011;
    localparam logic [7:0] PID_NAK   = 8'b0101_1010;

    typedef enum logic [2:0] {S_IDLE, S_TOKEN, S_DATA, S_WHAND, S_RDATA, S_SHAND} state_t;

    state_t             state_q, state_d;
    logic               sst_q, sst_d, ssd_q, ssd_d, ssh_q, ssh_d, rds_q, rds_d, rhs_q, rhs_d;
    logic [7:0]         pid_q, pid_d;
    logic               done_q, done_d, succ_q, succ_d, dup_q, dup_d, rw_q, rw_d;
    logic [3:0]         retry_q, retry_d;
    logic [TMW-1:0]     tmo_q, tmo_d;
    logic [EPW-1:0]     ep_q, ep_d;
    logic [(1<<EPW)-1:0] tog_q;
    logic               flip;

    // A real result in the last wait cycle takes precedence over the timeout.
    logic tmo_hit, hand_ok, hand_fail, data_good, data_bad, can_retry, cur_tog;
    assign tmo_hit   = (tmo_q == TMW'(TIMEOUT_CYC - 1));
    assign hand_ok   = rx_hand_valid & rx_ack & ~rx_nak & ~rx_hand_fail;
    assign hand_fail = rx_hand_fail | rx_nak | (tmo_hit & ~(rx_hand_valid & rx_ack));
    assign data_good = rx_data_done & rx_data_ok & ~rx_data_fail;
    assign data_bad  = rx_data_fail | (tmo_hit & ~data_good);
    assign can_retry = (retry_q < 4'(MAX_RETRY));
    assign cur_tog   = tog_q[ep_q];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_TOKEN;
            S_TOKEN: if (done_send_token) state_d = rw_q ? S_DATA : S_RDATA;
            S_DATA:  if (done_send_data) state_d = S_WHAND;
            S_WHAND: begin
                if (hand_fail)    state_d = can_retry ? S_DATA : S_IDLE;
                else if (hand_ok) state_d = S_IDLE;
            end
            S_RDATA: begin
                if (data_bad)       state_d = can_retry ? S_SHAND : S_IDLE;
                else if (data_good) state_d = S_SHAND;
            end
            S_SHAND: if (done_send_hand) state_d = (pid_q == PID_ACK) ? S_IDLE : S_RDATA;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sst_d   = 1'b0;
        ssd_d   = 1'b0;
        ssh_d   = 1'b0;
        rds_d   = 1'b0;
        rhs_d   = 1'b0;
        done_d  = 1'b0;
        flip    = 1'b0;
        pid_d   = pid_q;
        succ_d  = succ_q;
        dup_d   = dup_q;
        retry_d = retry_q;
        rw_d    = rw_q;
        ep_d    = ep_q;
        tmo_d   = '0;
        case (state_q)
            S_IDLE: if (start) begin
                rw_d    = read_write;
                ep_d    = ep;
                retry_d = 4'd0;
                succ_d  = 1'b0;
                dup_d   = 1'b0;
                sst_d   = 1'b1;
                pid_d   = read_write ? PID_OUT : PID_IN;
            end
            S_TOKEN: if (done_send_token) begin
                if (rw_q) begin
                    ssd_d = 1'b1;
                    pid_d = cur_tog ? PID_DATA1 : PID_DATA0;
                end else begin
                    rds_d = 1'b1;
                end
            end
            S_DATA: if (done_send_data) rhs_d = 1'b1;
            S_WHAND: begin
                tmo_d = tmo_q + TMW'(1);
                if (hand_fail) begin
                    if (can_retry) begin
                        retry_d = retry_q + 4'd1;
                        ssd_d   = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        succ_d = 1'b0;
                    end
                end else if (hand_ok) begin
                    flip   = 1'b1;
                    done_d = 1'b1;
                    succ_d = 1'b1;
                end
            end
            S_RDATA: begin
                tmo_d = tmo_q + TMW'(1);
                if (data_bad) begin
                    if (can_retry) begin
                        retry_d = retry_q + 4'd1;
                        ssh_d   = 1'b1;
                        pid_d   = PID_NAK;
                    end else begin
                        done_d = 1'b1;
                        succ_d = 1'b0;
                    end
                end else if (data_good) begin
                    ssh_d = 1'b1;
                    pid_d = PID_ACK;
                    dup_d = (rx_data_toggle != cur_tog);
                    flip  = (rx_data_toggle == cur_tog);
                end
            end
            S_SHAND: if (done_send_hand) begin
                if (pid_q == PID_ACK) begin
                    done_d = 1'b1;
                    succ_d = 1'b1;
                end else begin
                    rds_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sst_q   <= 1'b0;
            ssd_q   <= 1'b0;
            ssh_q   <= 1'b0;
            rds_q   <= 1'b0;
            rhs_q   <= 1'b0;
            pid_q   <= 8'd0;
            done_q  <= 1'b0;
            succ_q  <= 1'b0;
            dup_q   <= 1'b0;
            retry_q <= 4'd0;
            tmo_q   <= '0;
            rw_q    <= 1'b0;
            ep_q    <= '0;
        end else begin
            sst_q   <= sst_d;
            ssd_q   <= ssd_d;
            ssh_q   <= ssh_d;
            rds_q   <= rds_d;
            rhs_q   <= rhs_d;
            pid_q   <= pid_d;
            done_q  <= done_d;
            succ_q  <= succ_d;
            dup_q   <= dup_d;
            retry_q <= retry_d;
            tmo_q   <= tmo_d;
            rw_q    <= rw_d;
            ep_q    <= ep_d;
        end
    end

    // Clearing beats a same-cycle flip so software can force DATA0 unconditionally.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)          tog_q <= '0;
        else if (clr_toggle) tog_q <= '0;
        else if (flip)       tog_q[ep_q] <= ~tog_q[ep_q];
    end

    assign start_send_token = sst_q;
    assign start_send_data  = ssd_q;
    assign start_send_hand  = ssh_q;
    assign r_data_start     = rds_q;
    assign r_hand_start     = rhs_q;
    assign pid              = pid_q;
    assign busy             = (state_q != S_IDLE);
    assign system_done      = done_q;
    assign process_success  = succ_q;
    assign data_dup         = dup_q;
    assign retry_count      = retry_q;
endmodule

// File: tb/tb_usb_txn_ctrl.sv
module tb_usb_txn_ctrl;
    localparam int TMO = 12;
    localparam int MAXR = 8;

    logic clk, rst_l, start, read_write, clr_toggle;
    logic [1:0] ep;
    logic done_send_token, done_send_data, done_send_hand;
    logic rx_hand_valid, rx_ack, rx_nak, rx_hand_fail;
    logic rx_data_done, rx_data_ok, rx_data_fail, rx_data_toggle;
    logic start_send_token, start_send_data, start_send_hand, r_data_start, r_hand_start;
    logic [7:0] pid;
    logic busy, system_done, process_success, data_dup;
    logic [3:0] retry_count;

    usb_txn_ctrl #(.NUM_EP(4), .MAX_RETRY(MAXR), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_l(rst_l), .start(start), .read_write(read_write), .ep(ep),
        .clr_toggle(clr_toggle), .done_send_token(done_send_token),
        .done_send_data(done_send_data), .done_send_hand(done_send_hand),
        .rx_hand_valid(rx_hand_valid), .rx_ack(rx_ack), .rx_nak(rx_nak),
        .rx_hand_fail(rx_hand_fail), .rx_data_done(rx_data_done), .rx_data_ok(rx_data_ok),
        .rx_data_fail(rx_data_fail), .rx_data_toggle(rx_data_toggle),
        .start_send_token(start_send_token), .start_send_data(start_send_data),
        .start_send_hand(start_send_hand), .r_data_start(r_data_start),
        .r_hand_start(r_hand_start), .pid(pid), .busy(busy), .system_done(system_done),
        .process_success(process_success), .data_dup(data_dup), .retry_count(retry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_ssd = 0;
    bit run_chk = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One-cycle pulse masks for fire()
    localparam logic [11:0] ST  = 12'h800, DTK = 12'h400, DDT = 12'h200, DHS = 12'h100;
    localparam logic [11:0] HV  = 12'h080, ACK = 12'h040, NAK = 12'h020, HF  = 12'h010;
    localparam logic [11:0] RDD = 12'h008, RDO = 12'h004, RDF = 12'h002, CLR = 12'h001;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fire(input logic [11:0] v);
        {start, done_send_token, done_send_data, done_send_hand, rx_hand_valid, rx_ack,
         rx_nak, rx_hand_fail, rx_data_done, rx_data_ok, rx_data_fail, clr_toggle} = v;
        tick();
        {start, done_send_token, done_send_data, done_send_hand, rx_hand_valid, rx_ack,
         rx_nak, rx_hand_fail, rx_data_done, rx_data_ok, rx_data_fail, clr_toggle} = '0;
    endtask

    // Reference model: what the host controller should be doing, tracked as "what it waits for".
    localparam int W_IDLE = 0, W_TOKEN = 1, W_DATA_SENT = 2, W_HANDSHAKE = 3, W_RX_DATA = 4, W_HAND_SENT = 5;
    int         m_wait, m_age;
    logic       m_sst, m_ssd, m_ssh, m_rds, m_rhs, m_done, m_succ, m_dup, m_out;
    logic [7:0] m_pid;
    logic [3:0] m_retry;
    logic [1:0] m_ep;
    logic       m_tog [4];

    task automatic m_finish(input logic ok);
        m_wait = W_IDLE;
        m_done = 1'b1;
        m_succ = ok;
    endtask

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            m_wait = W_IDLE; m_age = 0;
            {m_sst, m_ssd, m_ssh, m_rds, m_rhs, m_done, m_succ, m_dup, m_out} = '0;
            m_pid = 8'h00; m_retry = 4'd0; m_ep = 2'd0;
            for (int i = 0; i < 4; i++) m_tog[i] = 1'b0;
        end else begin
            logic do_flip, bad, good;
            do_flip = 1'b0;
            {m_sst, m_ssd, m_ssh, m_rds, m_rhs, m_done} = '0;
            if (m_wait == W_IDLE) begin
                if (start) begin
                    m_out = read_write; m_ep = ep; m_retry = 4'd0;
                    m_succ = 1'b0; m_dup = 1'b0; m_sst = 1'b1;
                    m_pid = read_write ? 8'h87 : 8'h96;
                    m_wait = W_TOKEN;
                end
            end else if (m_wait == W_TOKEN) begin
                if (done_send_token) begin
                    m_age = 0;
                    if (m_out) begin
                        m_ssd = 1'b1; m_pid = m_tog[m_ep] ? 8'hD2 : 8'hC3; m_wait = W_DATA_SENT;
                    end else begin
                        m_rds = 1'b1; m_wait = W_RX_DATA;
                    end
                end
            end else if (m_wait == W_DATA_SENT) begin
                if (done_send_data) begin
                    m_rhs = 1'b1; m_age = 0; m_wait = W_HANDSHAKE;
                end
            end else if (m_wait == W_HANDSHAKE) begin
                m_age++;
                good = rx_hand_valid && rx_ack;
                bad  = rx_hand_fail || rx_nak || (m_age == TMO && !good);
                if (bad) begin
                    if (m_retry < MAXR) begin
                        m_retry++; m_ssd = 1'b1; m_wait = W_DATA_SENT;
                    end else m_finish(1'b0);
                end else if (good) begin
                    do_flip = 1'b1; m_finish(1'b1);
                end
            end else if (m_wait == W_RX_DATA) begin
                m_age++;
                good = rx_data_done && rx_data_ok && !rx_data_fail;
                bad  = rx_data_fail || (m_age == TMO && !good);
                if (bad) begin
                    if (m_retry < MAXR) begin
                        m_retry++; m_ssh = 1'b1; m_pid = 8'h5A; m_wait = W_HAND_SENT;
                    end else m_finish(1'b0);
                end else if (good) begin
                    m_dup = (rx_data_toggle != m_tog[m_ep]);
                    do_flip = !m_dup;
                    m_ssh = 1'b1; m_pid = 8'h4B; m_wait = W_HAND_SENT;
                end
            end else if (m_wait == W_HAND_SENT) begin
                if (done_send_hand) begin
                    if (m_pid == 8'h4B) m_finish(1'b1);
                    else begin
                        m_rds = 1'b1; m_age = 0; m_wait = W_RX_DATA;
                    end
                end
            end
            if (do_flip) m_tog[m_ep] = !m_tog[m_ep];
            if (clr_toggle) for (int i = 0; i < 4; i++) m_tog[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (start_send_data) n_ssd++;
        if (rst_l && run_chk)
            chk("cycle", {11'd0, busy, system_done, process_success, data_dup,
                          start_send_token, start_send_data, start_send_hand, r_data_start,
                          r_hand_start, retry_count, pid},
                         {11'd0, (m_wait != W_IDLE), m_done, m_succ, m_dup,
                          m_sst, m_ssd, m_ssh, m_rds, m_rhs, m_retry, m_pid});
    end

    function automatic logic [31:0] all_out();
        return {11'd0, busy, system_done, process_success, data_dup, start_send_token,
                start_send_data, start_send_hand, r_data_start, r_hand_start, retry_count, pid};
    endfunction

    initial begin
        int k, base;
        rst_l = 1'b1; read_write = 1'b0; ep = 2'd0; rx_data_toggle = 1'b0;
        {start, done_send_token, done_send_data, done_send_hand, rx_hand_valid, rx_ack,
         rx_nak, rx_hand_fail, rx_data_done, rx_data_ok, rx_data_fail, clr_toggle} = '0;
        #3 rst_l = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_l = 1'b1;
        chk("reset_outputs", all_out(), 32'd0);
        run_chk = 1'b1;

        // OUT ep2, clean ACK, then repeat uses DATA1
        read_write = 1'b1; ep = 2'd2;
        fire(ST);        chk("out_token_pid", {start_send_token, pid}, {1'b1, 8'h87});
        fire(DTK);       chk("out_data0_pid", {start_send_data, pid}, {1'b1, 8'hC3});
        fire(DDT);       chk("out_hand_start", r_hand_start, 1);
        fire(HV | ACK);  chk("out_success", {system_done, process_success, busy}, 3'b110);
        tick();          chk("done_one_cycle", system_done, 0);
        fire(ST); fire(DTK);
        chk("out_data1_pid", pid, 8'hD2);
        fire(DDT); fire(HV | ACK);

        // OUT ep1 NAK on every attempt -> retries exhausted
        ep = 2'd1; base = n_ssd;
        fire(ST); fire(DTK);
        for (int i = 0; i < MAXR + 1; i++) begin
            fire(DDT); fire(HV | NAK);
        end
        chk("nak_ssd_strobes", n_ssd - base, MAXR + 1);
        chk("nak_abort", {system_done, process_success, retry_count}, {2'b10, 4'd8});

        // IN ep0: silent receiver times out, then duplicate data is ACKed
        read_write = 1'b0; ep = 2'd0;
        fire(ST); fire(DTK);
        chk("in_rdata_start", r_data_start, 1);
        k = 0;
        while (k < 40 && !start_send_hand) begin tick(); k++; end
        chk("in_timeout_cycles", k, TMO);
        chk("in_nak_pid", {pid, retry_count}, {8'h5A, 4'd1});
        fire(DHS);       chk("in_rdata_restart", r_data_start, 1);
        rx_data_toggle = 1'b1;
        fire(RDD | RDO); chk("in_ack_dup", {start_send_hand, pid, data_dup}, {1'b1, 8'h4B, 1'b1});
        fire(DHS);       chk("in_done", {system_done, process_success, data_dup}, 3'b111);

        // ep0 toggle stayed DATA0; ACK with clr_toggle keeps it DATA0
        read_write = 1'b1;
        fire(ST); fire(DTK); chk("dup_no_flip", pid, 8'hC3);
        fire(DDT); fire(HV | ACK | CLR);
        fire(ST); fire(DTK); chk("clr_beats_flip", pid, 8'hC3);
        fire(DDT); fire(HV | ACK | NAK);
        chk("ack_nak_retry", {start_send_data, retry_count, pid}, {1'b1, 4'd1, 8'hC3});
        fire(DDT); fire(HV | ACK);
        chk("retry_then_ok", process_success, 1);

        // IN ep3 in-sequence data flips the toggle to DATA1
        read_write = 1'b0; ep = 2'd3; rx_data_toggle = 1'b0;
        fire(ST); fire(DTK); fire(RDD | RDO);
        chk("in_no_dup", {pid, data_dup}, {8'h4B, 1'b0});
        fire(DHS);

        // Start while busy is ignored; asynchronous reset mid SEND_DATA
        read_write = 1'b1;
        fire(ST); fire(DTK);
        read_write = 1'b0; ep = 2'd1;
        fire(ST);        chk("busy_start_ignored", {busy, start_send_token, pid}, {2'b10, 8'hD2});
        #1 rst_l = 1'b0;
        #1 chk("async_reset_outputs", all_out(), 32'd0);
        tick(); tick();
        rst_l = 1'b1;
        read_write = 1'b1; ep = 2'd3;
        fire(ST); fire(DTK);
        chk("reset_clears_toggle", pid, 8'hC3);
        fire(DDT); fire(HV | ACK);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/usb_txn_ctrl.md
USB_TXN_CTRL -- requirements
Module: usb_txn_ctrl

Parameters
REQ-001 SHALL have parameter NUM_EP, default 4, number of endpoints with independent data-toggle state (>=1).
REQ-002 SHALL have parameter MAX_RETRY, default 8, number of retries allowed after a failed attempt (1..15).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, response-wait limit in clk cycles (>=2).

Interface
REQ-004 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have rst_l  input  1  asynchronous, active-low reset.
REQ-006 SHALL have start  input  1  one-cycle transaction request.
REQ-007 SHALL have read_write  input  1  transaction direction: 0 = IN (read), 1 = OUT (write); sampled with start.
REQ-008 SHALL have ep  input  EPW  endpoint index, EPW = max(1, clog2(NUM_EP)); sampled with start.
REQ-009 SHALL have clr_toggle  input  1  clears all endpoint toggles to DATA0.
REQ-010 SHALL have done_send_token, done_send_data, done_send_hand  input  1 each  completion pulses from the sender FSMs.
REQ-011 SHALL have rx_hand_valid, rx_ack, rx_nak, rx_hand_fail  input  1 each  handshake-receiver results.
REQ-012 SHALL have rx_data_done, rx_data_ok, rx_data_fail, rx_data_toggle  input  1 each  data-receiver results; rx_data_toggle = received DATA1.
REQ-013 SHALL have start_send_token, start_send_data, start_send_hand, r_data_start, r_hand_start  output  1 each  one-cycle sub-FSM start strobes.
REQ-014 SHALL have pid  output  8  PID for the active sender.
REQ-015 SHALL have busy, system_done, process_success, data_dup  output  1 each  status.
REQ-016 SHALL have retry_count  output  4  failures counted in the current transaction.

Function
REQ-017 SHALL implement states IDLE, SEND_TOKEN, SEND_DATA, WAIT_HAND, RECV_DATA, SEND_HAND.
REQ-018 SHALL register all strobes and pid: a strobe is high only in the first cycle of the entered state; pid is loaded in that same cycle and held until the next load.
REQ-019 SHALL, on start in IDLE, latch read_write and ep, clear retry_count, and enter SEND_TOKEN with start_send_token=1 and pid=8'b1000_0111 (OUT) or 8'b1001_0110 (IN).
REQ-020 SHALL ignore start while busy; busy = (state != IDLE).
REQ-021 SHALL, on done_send_token, go to SEND_DATA (OUT, start_send_data, pid = DATA0 8'b1100_0011 or DATA1 8'b1101_0010 per the ep toggle) or RECV_DATA (IN, r_data_start).
REQ-022 SHALL, on done_send_data, go to WAIT_HAND with r_hand_start.
REQ-023 SHALL run a timeout counter that is cleared on entry to WAIT_HAND/RECV_DATA and incremented each cycle; reaching TIMEOUT_CYC with no result is a failure.
REQ-024 SHALL, in WAIT_HAND, treat rx_hand_fail, rx_nak or timeout as a failure; rx_hand_valid&&rx_ack alone is success; nak wins over a simultaneous ack.
REQ-025 SHALL, on an OUT failure with retry_count<MAX_RETRY, increment retry_count and re-enter SEND_DATA with the same pid; otherwise go to IDLE with system_done=1, process_success=0.
REQ-026 SHALL, on OUT success, flip the ep toggle and go to IDLE with system_done=1, process_success=1.
REQ-027 SHALL, in RECV_DATA, on rx_data_fail or timeout with retry_count<MAX_RETRY, increment retry_count and enter SEND_HAND with pid=NAK 8'b0101_1010; at the limit, abort as in REQ-025.
REQ-028 SHALL, on rx_data_done&&rx_data_ok, enter SEND_HAND with pid=ACK 8'b0100_1011; record data_dup = (rx_data_toggle != ep toggle); flip the toggle only if not dup.
REQ-029 SHALL, on done_send_hand, re-enter RECV_DATA with r_data_start after NAK, or go to IDLE after ACK with system_done=1, process_success=1.
REQ-030 SHALL pulse system_done for exactly one cycle, the first in IDLE; process_success and data_dup hold until the next start.
REQ-031 SHALL give clr_toggle priority over a same-cycle toggle flip; it is honoured in any state.

Reset
REQ-032 SHALL, on rst_l low, immediately enter IDLE, clear all toggles, timeout and retry_count, and drive every output to 0, including mid-transaction.

Verification
REQ-033 OUT ep=2 toggle=0, done_send_token, done_send_data, ack -> pid 8'b1100_0011 on data, success=1, ep2 toggle=1; a repeat OUT uses 8'b1101_0010.
REQ-034 OUT with nak on every attempt, MAX_RETRY=8 -> 9 start_send_data strobes, retry_count=8, system_done with process_success=0.
REQ-035 IN with no receiver response -> fail after TIMEOUT_CYC cycles, NAK pid sent, r_data_start reissued.
REQ-036 IN ok with rx_data_toggle=1 while expected 0 -> ACK sent, data_dup=1, toggle stays 0.
REQ-037 ack and nak in the same cycle -> treated as a retry; clr_toggle during the ACK flip -> toggle=0.
REQ-038 rst_l low in SEND_DATA -> IDLE and all outputs 0 asynchronously; start while busy -> no effect.
